// File: rtl/barrel_thread_sequencer_if.sv
// Issue, writeback and wake bundle between the barrel thread sequencer and the pipeline.
// The master side is the sequencer; the slave side is fetch plus the writeback and wake owners.
interface barrel_thread_sequencer_if #(
  parameter int NUM_THREADS = 16,
  parameter int PC_WIDTH    = 12
);
  localparam int TID_W = $clog2(NUM_THREADS);

  logic                   issue_valid;
  logic                   issue_ready;
  logic [TID_W-1:0]       issue_tid;
  logic [PC_WIDTH-1:0]    issue_pc;
  logic                   wb_valid;
  logic [TID_W-1:0]       wb_tid;
  logic [PC_WIDTH-1:0]    wb_pc;
  logic                   wb_park;
  logic                   wake_valid;
  logic [TID_W-1:0]       wake_tid;
  logic                   wake_set_pc;
  logic [PC_WIDTH-1:0]    wake_pc;
  logic [NUM_THREADS-1:0] active_mask;
  logic [NUM_THREADS-1:0] inflight_mask;
  logic                   err;

  modport master (
    output issue_valid, issue_tid, issue_pc, active_mask, inflight_mask, err,
    input  issue_ready, wb_valid, wb_tid, wb_pc, wb_park,
           wake_valid, wake_tid, wake_set_pc, wake_pc
  );

  modport slave (
    input  issue_valid, issue_tid, issue_pc, active_mask, inflight_mask, err,
    output issue_ready, wb_valid, wb_tid, wb_pc, wb_park,
           wake_valid, wake_tid, wake_set_pc, wake_pc
  );
endinterface

// File: rtl/barrel_thread_sequencer.sv
// Round-robin issue sequencer for the barrel core: owns per-thread PC, active and in-flight
// state and offers one eligible thread per cycle to fetch.
module barrel_thread_sequencer #(
  parameter int                     NUM_THREADS       = 16,
  parameter int                     PC_WIDTH          = 12,
  parameter logic [PC_WIDTH-1:0]    STARTUP_ADDR      = '0,
  parameter logic [NUM_THREADS-1:0] RESET_ACTIVE_MASK = '1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  barrel_thread_sequencer_if.master  bus
);
  localparam int TID_W = $clog2(NUM_THREADS);

  typedef logic [PC_WIDTH-1:0] pc_t;

  pc_t                    pc_q [NUM_THREADS];
  pc_t                    pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0] active_q, active_d, inflight_q, inflight_d;
  logic [TID_W-1:0]       rr_q, rr_d, tid_q, tid_d;
  logic                   iv_q, iv_d, err_q, err_d;
  pc_t                    ipc_q, ipc_d;

  logic [NUM_THREADS-1:0] eligible, wb_sel, wb_hit, wake_sel;
  logic [NUM_THREADS-1:0] hi_oh, lo_oh, pick_oh;
  logic                   found_hi, found_lo, found, load, wb_err, wake_err;
  logic [TID_W-1:0]       hi_tid, lo_tid, pick_tid, pick_next;
  pc_t                    hi_pc, lo_pc, pick_pc;

  // One-hot decode keeps out-of-range tids (non power-of-two counts) from touching state.
  always_comb begin : decode
    wb_sel   = '0;
    wake_sel = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      wb_sel[i]   = bus.wb_valid && (bus.wb_tid == TID_W'(i));
      wake_sel[i] = bus.wake_valid && (bus.wake_tid == TID_W'(i));
    end
    wb_hit   = wb_sel & inflight_q;
    wb_err   = bus.wb_valid && (wb_hit == '0);
    wake_err = bus.wake_valid &&
               ((wake_sel == '0) ||
                (bus.wake_set_pc && ((wake_sel & inflight_q & ~wb_hit) != '0)));
  end

  // Rotating search: first eligible at or above rr_ptr, else lowest eligible below it.
  always_comb begin : search
    eligible = active_q & ~inflight_q;
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_oh    = '0;
    lo_oh    = '0;
    hi_tid   = '0;
    lo_tid   = '0;
    hi_pc    = '0;
    lo_pc    = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (eligible[i] && (i >= int'(rr_q)) && !found_hi) begin
        found_hi = 1'b1;
        hi_oh[i] = 1'b1;
        hi_tid   = TID_W'(i);
        hi_pc    = pc_q[i];
      end
      if (eligible[i] && (i < int'(rr_q)) && !found_lo) begin
        found_lo = 1'b1;
        lo_oh[i] = 1'b1;
        lo_tid   = TID_W'(i);
        lo_pc    = pc_q[i];
      end
    end
    found     = found_hi || found_lo;
    pick_oh   = found_hi ? hi_oh  : lo_oh;
    pick_tid  = found_hi ? hi_tid : lo_tid;
    pick_pc   = found_hi ? hi_pc  : lo_pc;
    pick_next = (pick_tid == TID_W'(NUM_THREADS - 1)) ? '0 : pick_tid + TID_W'(1);
  end

  always_comb begin : next_state
    pc_d       = pc_q;
    active_d   = (active_q & ~(wb_hit & {NUM_THREADS{bus.wb_park}})) | wake_sel;
    inflight_d = inflight_q & ~wb_hit;
    iv_d       = iv_q;
    tid_d      = tid_q;
    ipc_d      = ipc_q;
    rr_d       = rr_q;
    err_d      = err_q | wb_err | wake_err;
    load       = !iv_q || bus.issue_ready;
    // Wake PC is written after the writeback PC so it wins on a same-tid collision.
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (wb_hit[i])
        pc_d[i] = bus.wb_pc;
      if (wake_sel[i] && bus.wake_set_pc && (!inflight_q[i] || wb_hit[i]))
        pc_d[i] = bus.wake_pc;
    end
    if (load) begin
      iv_d = found;
      if (found) begin
        tid_d      = pick_tid;
        ipc_d      = pick_pc;
        inflight_d = inflight_d | pick_oh;
        rr_d       = pick_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_THREADS; i++)
        pc_q[i] <= STARTUP_ADDR;
      active_q   <= RESET_ACTIVE_MASK;
      inflight_q <= '0;
      rr_q       <= '0;
      iv_q       <= 1'b0;
      tid_q      <= '0;
      ipc_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      active_q   <= active_d;
      inflight_q <= inflight_d;
      rr_q       <= rr_d;
      iv_q       <= iv_d;
      tid_q      <= tid_d;
      ipc_q      <= ipc_d;
      err_q      <= err_d;
    end
  end

  assign bus.issue_valid   = iv_q;
  assign bus.issue_tid     = tid_q;
  assign bus.issue_pc      = ipc_q;
  assign bus.active_mask   = active_q;
  assign bus.inflight_mask = inflight_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_barrel_thread_sequencer.sv
// Bench for barrel_thread_sequencer: a 16-thread default instance and a 6-thread sparse-mask
// instance, each compared every cycle against a thread-table reference model.
module tb_barrel_thread_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n_16, reset_n_6;
  logic        issue_ready;
  logic        wb_valid, wb_park, wake_valid, wake_set_pc;
  logic [3:0]  wb_tid, wake_tid;
  logic [11:0] wb_pc, wake_pc;

  barrel_thread_sequencer_if #(.NUM_THREADS(16), .PC_WIDTH(12)) bus16 ();
  barrel_thread_sequencer_if #(.NUM_THREADS(6),  .PC_WIDTH(12)) bus6 ();

  assign bus16.issue_ready = issue_ready;
  assign bus16.wb_valid    = wb_valid;
  assign bus16.wb_tid      = wb_tid;
  assign bus16.wb_pc       = wb_pc;
  assign bus16.wb_park     = wb_park;
  assign bus16.wake_valid  = wake_valid;
  assign bus16.wake_tid    = wake_tid;
  assign bus16.wake_set_pc = wake_set_pc;
  assign bus16.wake_pc     = wake_pc;

  assign bus6.issue_ready  = issue_ready;
  assign bus6.wb_valid     = wb_valid;
  assign bus6.wb_tid       = wb_tid[2:0];
  assign bus6.wb_pc        = wb_pc;
  assign bus6.wb_park      = wb_park;
  assign bus6.wake_valid   = wake_valid;
  assign bus6.wake_tid     = wake_tid[2:0];
  assign bus6.wake_set_pc  = wake_set_pc;
  assign bus6.wake_pc      = wake_pc;

  barrel_thread_sequencer #(.NUM_THREADS(16), .PC_WIDTH(12)) dut16 (
    .clk(clk), .reset_n(reset_n_16), .bus(bus16));

  barrel_thread_sequencer #(.NUM_THREADS(6), .PC_WIDTH(12), .STARTUP_ADDR(12'h040),
                            .RESET_ACTIVE_MASK(6'b101010)) dut6 (
    .clk(clk), .reset_n(reset_n_6), .bus(bus6));

  // Reference thread table
  logic [11:0] m_pc [16];
  logic [15:0] m_active, m_inflight;
  int          m_rr;
  logic        m_iv, m_err;
  logic [3:0]  m_tid;
  logic [11:0] m_ipc;
  bit          m_tid_known;

  int compared = 0;
  int mismatched = 0;

  task automatic model_step(input int n, input logic rst, input logic [11:0] start,
                            input logic [15:0] rmask);
    logic [11:0] opc [16];
    logic [15:0] oinf, oact;
    int          orr, t;
    bit          wb_ok, hit;
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_pc[i] = start;
      m_active = rmask; m_inflight = '0; m_rr = 0;
      m_iv = 0; m_tid = '0; m_ipc = '0; m_err = 0; m_tid_known = 1;
      return;
    end
    opc = m_pc; oinf = m_inflight; oact = m_active; orr = m_rr;
    wb_ok = wb_valid && (int'(wb_tid) < n) && oinf[wb_tid];
    if (wb_valid) begin
      if (wb_ok) begin
        m_pc[wb_tid] = wb_pc;
        m_inflight[wb_tid] = 1'b0;
        if (wb_park) m_active[wb_tid] = 1'b0;
      end else m_err = 1;
    end
    if (wake_valid) begin
      if (int'(wake_tid) >= n) m_err = 1;
      else begin
        m_active[wake_tid] = 1'b1;
        if (wake_set_pc) begin
          if (!oinf[wake_tid] || (wb_ok && wb_tid == wake_tid)) m_pc[wake_tid] = wake_pc;
          else m_err = 1;
        end
      end
    end
    if (!m_iv || issue_ready) begin
      hit = 0;
      for (int k = 0; k < n; k++) begin
        t = (orr + k) % n;
        if (!hit && oact[t] && !oinf[t]) begin
          hit = 1;
          m_tid = 4'(t);
          m_ipc = opc[t];
          m_inflight[t] = 1'b1;
          m_rr = (t + 1) % n;
        end
      end
      m_iv = hit;
      m_tid_known = hit;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input bit b6);
    logic        o_iv, o_err;
    logic [3:0]  o_tid;
    logic [11:0] o_pc;
    logic [15:0] o_act, o_inf;
    if (b6) begin
      o_iv = bus6.issue_valid; o_tid = {1'b0, bus6.issue_tid}; o_pc = bus6.issue_pc;
      o_act = {10'b0, bus6.active_mask}; o_inf = {10'b0, bus6.inflight_mask}; o_err = bus6.err;
    end else begin
      o_iv = bus16.issue_valid; o_tid = bus16.issue_tid; o_pc = bus16.issue_pc;
      o_act = bus16.active_mask; o_inf = bus16.inflight_mask; o_err = bus16.err;
    end
    check("issue_valid", 32'(o_iv), 32'(m_iv));
    if (m_tid_known) begin
      check("issue_tid", 32'(o_tid), 32'(m_tid));
      check("issue_pc", 32'(o_pc), 32'(m_ipc));
    end
    check("active_mask", 32'(o_act), 32'(m_active));
    check("inflight_mask", 32'(o_inf), 32'(m_inflight));
    check("err", 32'(o_err), 32'(m_err));
  endtask

  task automatic tick(input bit b6);
    @(posedge clk);
    if (b6) model_step(6, reset_n_6, 12'h040, 16'h002A);
    else    model_step(16, reset_n_16, 12'h000, 16'hFFFF);
    #1;
    check_all(b6);
  endtask

  task automatic idle();
    wb_valid = 0; wb_park = 0; wb_tid = '0; wb_pc = '0;
    wake_valid = 0; wake_set_pc = 0; wake_tid = '0; wake_pc = '0;
  endtask

  task automatic do_wb(input int t, input logic [11:0] pc, input bit park);
    wb_valid = 1; wb_tid = 4'(t); wb_pc = pc; wb_park = park;
  endtask

  task automatic do_wake(input int t, input bit set_pc, input logic [11:0] pc);
    wake_valid = 1; wake_tid = 4'(t); wake_set_pc = set_pc; wake_pc = pc;
  endtask

  task automatic random_cycle(input bit b6);
    int n, t;
    n = b6 ? 6 : 16;
    issue_ready = ($urandom_range(0, 3) != 0);
    idle();
    if ($urandom_range(0, 1) == 1) begin
      t = $urandom_range(0, b6 ? 7 : 15);
      if ($urandom_range(0, 9) != 0)
        for (int k = 0; k < n; k++)
          if (m_inflight[(t + k) % n]) begin t = (t + k) % n; break; end
      do_wb(t, 12'($urandom), $urandom_range(0, 3) == 0);
    end
    if ($urandom_range(0, 3) == 0)
      do_wake($urandom_range(0, b6 ? 7 : 15), $urandom_range(0, 1) == 1, 12'($urandom));
    tick(b6);
  endtask

  initial begin
    idle();
    issue_ready = 1;
    reset_n_16 = 0;
    reset_n_6 = 0;
    repeat (2) tick(0);

    // 16-thread instance: initial rotation 0..15, then nothing left to issue
    reset_n_16 = 1;
    repeat (18) tick(0);

    do_wb(3, 12'h004, 0); tick(0); idle();
    repeat (4) tick(0);

    do_wb(5, 12'h055, 1); tick(0); idle();
    repeat (3) tick(0);
    do_wake(5, 1, 12'h100); tick(0); idle();
    repeat (3) tick(0);

    // Same-cycle writeback with park and wake on tid 2, then again with a wake PC
    do_wb(2, 12'h022, 1); do_wake(2, 0, 12'h000); tick(0); idle();
    repeat (3) tick(0);
    do_wb(2, 12'h0A2, 1); do_wake(2, 1, 12'h0B2); tick(0); idle();
    repeat (3) tick(0);

    // Fetch stalled: loaded thread held while writebacks continue; stray wb flags err
    issue_ready = 0;
    do_wb(7, 12'h077, 0); tick(0); idle();
    tick(0);
    do_wb(8, 12'h088, 0); tick(0); idle();
    do_wb(8, 12'h099, 0); tick(0); idle();
    repeat (5) tick(0);
    issue_ready = 1;
    repeat (3) tick(0);

    repeat (400) random_cycle(0);

    // 6-thread instance with sparse reset mask
    idle();
    issue_ready = 1;
    reset_n_16 = 0;
    repeat (2) tick(1);
    reset_n_6 = 1;
    repeat (6) tick(1);
    do_wb(5, 12'h005, 0); tick(1); idle();
    do_wb(1, 12'h001, 0); tick(1); idle();
    do_wb(3, 12'h003, 0); tick(1); idle();
    repeat (4) tick(1);
    do_wb(6, 12'h006, 0); tick(1); idle();
    do_wake(7, 1, 12'h007); tick(1); idle();
    repeat (2) tick(1);

    repeat (150) random_cycle(1);
    idle();
    reset_n_6 = 0;
    tick(1);
    reset_n_6 = 1;
    repeat (150) random_cycle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
